// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   state_t     : fetch controller states
//   INSTR_BYTES : default PC increment per sequential fetch
//   ALIGN_BITS  : low address bits cleared to word-align an address
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    VALID = 2'd3
  } state_t;

  localparam int INSTR_BYTES = 4;

  // Word-align mask: addresses are used with these low bits forced to zero.
  localparam int ALIGN_BITS = 2;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage wrapped around an external PC register.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   pc_q                    : current PC from the PC register
//   pc_d, pc_en             : next PC and load enable for the PC register
//   imem_req, imem_addr     : instruction-memory request, word-aligned address
//   imem_ack, imem_rdata    : memory response, completes the request
//   redirect_valid/_pc      : branch/exception redirect from execute
//   out_valid/ready/instr/pc: instruction handshake towards decode
//
// state | meaning
// IDLE  | after reset, a redirect may load the PC, then start fetching
// REQ   | request for pc_q outstanding
// DRAIN | redirected while a request was outstanding, wait out the stale ack
// VALID | instruction held for decode until accepted or redirected
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_BYTES = fetch_pkg::INSTR_BYTES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pc_q,
  output logic [ADDR_WIDTH-1:0] pc_d,
  output logic                  pc_en,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc
);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pend_pc_q;
  logic [ADDR_WIDTH-1:0] pc_aligned;
  logic [ADDR_WIDTH-1:0] redirect_aligned;
  logic                  pc_en_c;
  logic [ADDR_WIDTH-1:0] pc_d_c;

  assign pc_aligned       = {pc_q[ADDR_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
  assign redirect_aligned = {redirect_pc[ADDR_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};

  assign imem_addr = pc_aligned;
  // rst_n gating keeps the request and PC load dead for the whole reset window.
  assign imem_req  = rst_n && ((state_q == REQ) || (state_q == DRAIN));
  assign out_valid = (state_q == VALID);
  assign pc_en     = rst_n && pc_en_c;
  assign pc_d      = pc_d_c;

  // The PC only moves on an ack while a request is outstanding, so imem_addr
  // stays stable for the whole request.
  always_comb begin
    pc_en_c = 1'b0;
    pc_d_c  = pc_aligned;
    case (state_q)
      IDLE, VALID: begin
        if (redirect_valid) begin
          pc_en_c = 1'b1;
          pc_d_c  = redirect_aligned;
        end
      end
      REQ: begin
        if (imem_ack) begin
          pc_en_c = 1'b1;
          pc_d_c  = redirect_valid ? redirect_aligned
                                   : pc_aligned + ADDR_WIDTH'(INSTR_BYTES);
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          pc_en_c = 1'b1;
          pc_d_c  = redirect_valid ? redirect_aligned : pend_pc_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_instr <= '0;
      out_pc    <= '0;
      pend_pc_q <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (imem_ack && !redirect_valid) begin
            out_instr <= imem_rdata;
            out_pc    <= pc_aligned;
            state_q   <= VALID;
          end else if (redirect_valid && !imem_ack) begin
            pend_pc_q <= redirect_aligned;
            state_q   <= DRAIN;
          end
          // ack together with redirect: data dropped, refetch from the target
        end
        DRAIN: begin
          if (redirect_valid) pend_pc_q <= redirect_aligned;
          if (imem_ack)       state_q   <= REQ;
        end
        VALID: begin
          if (out_ready || redirect_valid) state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .pc_q(pc_q), .pc_d(pc_d), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  // PC register owned by the parent.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc_q <= 32'h0;
    else if (pc_en) pc_q <= pc_d;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_xfer = 0;

  // memory model state
  int          mcnt = 0;
  int          mlat = 0;
  bit          rand_lat = 1'b0;
  logic [31:0] req_addr = 32'h0;

  // stream model state
  logic [31:0] exp_pc = 32'h0;
  bit          hold_prev = 1'b0;
  logic [31:0] hold_pc, hold_instr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A00001;
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive_mem();
    imem_ack   = imem_req && (mcnt >= mlat);
    imem_rdata = imem_ack ? memf(imem_addr) : $urandom;
  endtask

  task automatic settle();
    drive_mem();
    #1;
  endtask

  // Per-cycle comparison against the instruction-stream model, sampled at negedge.
  task automatic model_cycle();
    chk("addr_align", imem_addr, {pc_q[31:2], 2'b00});
    chk("req_and_valid", {31'b0, imem_req & out_valid}, 32'h0);
    if (imem_req && mcnt > 0) chk("addr_stable", imem_addr, req_addr);
    if (imem_req && !imem_ack) chk("pc_en_wait", {31'b0, pc_en}, 32'h0);
    if (hold_prev) begin
      chk("hold_valid", {31'b0, out_valid}, 32'h1);
      chk("hold_pc", out_pc, hold_pc);
      chk("hold_instr", out_instr, hold_instr);
    end
    if (out_valid && out_ready) begin
      chk("stream_pc", out_pc, exp_pc);
      chk("stream_instr", out_instr, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_xfer++;
    end
    if (redirect_valid) exp_pc = redirect_pc & 32'hFFFFFFFC;
    hold_prev  = out_valid && !out_ready && !redirect_valid;
    hold_pc    = out_pc;
    hold_instr = out_instr;
    if (imem_req) begin
      if (mcnt == 0) req_addr = imem_addr;
      if (imem_ack) begin
        mcnt = 0;
        if (rand_lat) mlat = $urandom_range(0, 3);
      end else begin
        mcnt++;
      end
    end
  endtask

  task automatic step();
    drive_mem();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    #3;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_pc_en", {31'b0, pc_en}, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    @(posedge clk); #1;
    redirect_valid = 1'b0; rst_n = 1'b1;

    // first fetch, zero-wait memory
    settle();
    chk("idle_req", {31'b0, imem_req}, 32'h0);
    step();
    settle();
    chk("f0_req", {31'b0, imem_req}, 32'h1);
    chk("f0_addr", imem_addr, 32'h0);
    chk("f0_pc_en", {31'b0, pc_en}, 32'h1);
    chk("f0_pc_d", pc_d, 32'h4);
    step();
    chk("f0_valid", {31'b0, out_valid}, 32'h1);
    chk("f0_instr", out_instr, 32'hE3A00001);
    chk("f0_out_pc", out_pc, 32'h0);
    chk("f0_pc_q", pc_q, 32'h4);

    // back-pressure
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_instr", out_instr, 32'hE3A00001);
      chk("bp_req", {31'b0, imem_req}, 32'h0);
      chk("bp_pc_q", pc_q, 32'h4);
      step();
    end
    out_ready = 1'b1;
    settle();
    step();
    out_ready = 1'b0;
    mlat = 3;
    settle();
    chk("bp_next_addr", imem_addr, 32'h4);
    chk("bp_no_dup", {31'b0, out_valid}, 32'h0);

    // redirects during an outstanding request
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    settle();
    chk("rd_no_pc_en", {31'b0, pc_en}, 32'h0);
    step();
    redirect_valid = 1'b0;
    settle();
    chk("drain_req", {31'b0, imem_req}, 32'h1);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    settle();
    chk("drain_addr", imem_addr, 32'h4);
    step();
    redirect_valid = 1'b0;
    settle();
    chk("drain_ack", {31'b0, imem_ack}, 32'h1);
    chk("drain_pc_en", {31'b0, pc_en}, 32'h1);
    chk("drain_pc_d", pc_d, 32'h200);
    chk("drain_valid", {31'b0, out_valid}, 32'h0);
    step();
    mlat = 0;
    settle();
    chk("drain_next", imem_addr, 32'h200);
    chk("drain_discard", {31'b0, out_valid}, 32'h0);

    // redirect coincident with ack
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    settle();
    chk("co_pc_en", {31'b0, pc_en}, 32'h1);
    chk("co_pc_d", pc_d, 32'h80);
    step();
    redirect_valid = 1'b0;
    settle();
    chk("co_addr", imem_addr, 32'h80);
    chk("co_valid", {31'b0, out_valid}, 32'h0);
    chk("co_pc_d_seq", pc_d, 32'h84);
    step();
    chk("co_out_pc", out_pc, 32'h80);
    out_ready = 1'b1;
    settle();
    step();
    out_ready = 1'b0;

    // wrap-around and unaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    settle();
    chk("wr_pc_d", pc_d, 32'hFFFFFFFC);
    step();
    redirect_valid = 1'b0;
    settle();
    chk("wr_addr", imem_addr, 32'hFFFFFFFC);
    chk("wr_pc_wrap", pc_d, 32'h0);
    step();
    chk("wr_out_pc", out_pc, 32'hFFFFFFFC);
    chk("wr_pc_q", pc_q, 32'h0);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103;
    settle();
    chk("ua_pc_d", pc_d, 32'h100);
    step();
    out_ready = 1'b0; redirect_valid = 1'b0;
    settle();
    chk("ua_addr", imem_addr, 32'h100);

    // reset while a request is outstanding
    mlat = 3;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    rst_n = 1'b0;
    #1;
    chk("mrst_req", {31'b0, imem_req}, 32'h0);
    chk("mrst_valid", {31'b0, out_valid}, 32'h0);
    chk("mrst_pc_en", {31'b0, pc_en}, 32'h0);
    exp_pc = 32'h0; mcnt = 0; hold_prev = 1'b0;
    @(posedge clk); #1;
    redirect_valid = 1'b0; rst_n = 1'b1; mlat = 0;
    settle();
    chk("mrst_idle", {31'b0, imem_req}, 32'h0);
    step();
    settle();
    chk("mrst_restart_req", {31'b0, imem_req}, 32'h1);
    chk("mrst_restart_addr", imem_addr, 32'h0);
    step();

    // randomized traffic
    rand_lat = 1'b1;
    n_xfer = 0;
    for (int i = 0; i < 3000; i++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom;
      step();
    end
    chk("progress", {31'b0, n_xfer > 200}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage that sits directly around the PC register.
- Consumes the current PC (pc_q) and issues an instruction-memory request for it.
- Produces the next PC and its load enable (pc_d / pc_en) to drive the PC register.
- Hands the fetched instruction to decode over a valid/ready handshake.
- Handles branch redirects from execute, including redirects that arrive while a memory request is in flight.

Parameters:
ADDR_WIDTH, 32, width of PC and instruction-memory address
DATA_WIDTH, 32, width of instruction word
INSTR_BYTES, 4, PC increment per sequential fetch

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
pc_q  input  ADDR_WIDTH  current PC from the PC register
pc_d  output  ADDR_WIDTH  next PC value for the PC register
pc_en  output  1  PC register load enable
imem_req  output  1  instruction-memory request
imem_addr  output  ADDR_WIDTH  request address, word aligned
imem_ack  input  1  memory response valid; completes the request
imem_rdata  input  DATA_WIDTH  instruction word, valid with imem_ack
redirect_valid  input  1  branch/exception redirect, single-cycle pulse or level
redirect_pc  input  ADDR_WIDTH  redirect target
out_valid  output  1  instruction available to decode
out_ready  input  1  decode accepts instruction
out_instr  output  DATA_WIDTH  fetched instruction
out_pc  output  ADDR_WIDTH  address of out_instr

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- While rst_n is low:
  - state=IDLE; out_valid=0; out_instr=0; out_pc=0; pend_pc=0.
  - imem_req=0 and pc_en=0 (forced combinationally).
  - The PC register's own reset must be asserted by the parent in the same window.
- Reset mid-request: the request is abandoned immediately; imem_req drops with rst_n.
- Alignment:
  - imem_addr = {pc_q[ADDR_WIDTH-1:2], 2'b00}.
  - redirect_pc[1:0] is forced to 0 before use.
  - pc_d arithmetic is modulo 2^ADDR_WIDTH, so 0xFFFFFFFC+4 = 0x00000000.
- imem protocol:
  - imem_req is a registered state decode.
  - imem_addr stays stable from req rise until the ack cycle, so pc_en is never asserted in REQ/DRAIN before ack.
  - No cancellation of an issued request.
- pc_en/pc_d are combinational from state plus inputs. Because the PC register has 1-cycle latency, pc_q reflects the update in the next cycle.
- FSM states:
  - IDLE: entered after reset.
    - redirect_valid: pc_en=1, pc_d=redirect_pc.
    - Always goes to REQ next.
  - REQ: imem_req=1.
    - ack with no redirect: capture out_instr=imem_rdata, out_pc=pc_q; pc_en=1, pc_d=pc_q+INSTR_BYTES; go to VALID.
    - redirect with no ack: pend_pc=redirect_pc; go to DRAIN.
    - redirect and ack in the same cycle: data discarded; pc_en=1, pc_d=redirect_pc; stay in REQ (new address next cycle).
  - DRAIN: imem_req=1; waits out the stale request.
    - A further redirect overwrites pend_pc (latest wins).
    - On ack: data discarded; pc_en=1, pc_d = redirect_pc if redirect is present this cycle, else pend_pc; go to REQ.
  - VALID: out_valid=1; outputs held stable until accepted.
    - out_ready=1: go to REQ.
    - redirect_valid: pc_en=1, pc_d=redirect_pc; go to REQ.
    - Redirect and out_ready together: the transfer counts, and the redirect applies. Flushing decode is the redirect source's job.
- Throughput: one instruction per 2 cycles minimum (REQ then VALID) with zero-wait memory. Back-pressure from out_ready never drops or duplicates an instruction.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum (IDLE, REQ, DRAIN, VALID);
  - INSTR_BYTES;
  - word-align mask.
- No sub-module. The PC register is instantiated by the parent next to this block and wired pc_d->d, pc_en->enable, q->pc_q.

Test Plan:
- Reset, PC=0, memory acks next cycle with 0xE3A00001 -> imem_addr=0x0, out_valid with out_instr=0xE3A00001/out_pc=0x0, then pc_q=0x4 and next request addr 0x4.
- Hold out_ready=0 for 5 cycles in VALID -> out_instr/out_pc stable, imem_req=0, pc_q unchanged at 0x4; release ready -> single transfer, next fetch addr 0x4.
- Redirect to 0x100 while REQ waits (ack delayed 3 cycles), second redirect to 0x200 in DRAIN -> stale data discarded, out_valid stays 0, next imem_addr=0x200.
- Redirect to 0x80 coincident with imem_ack in REQ -> data discarded, pc_en=1/pc_d=0x80, next imem_addr=0x80.
- pc_q=0xFFFFFFFC with ack -> pc_d=0x00000000; redirect_pc=0x103 -> imem_addr=0x100.
- Deassert rst_n while imem_req=1 -> imem_req/out_valid/pc_en go 0 asynchronously; after release, fetch restarts from pc_q=0.
